// File: rtl/a2d_slv_pkg.sv
// Shared types and frame-layout constants for the A2D SPI responder.
// Build option A2D_SLV_INVERT_EN (see a2d_spi_slave.sv) needs nothing from here.
package a2d_slv_pkg;

  typedef enum logic {IDLE, SHIFT} a2d_slv_state_t;

  localparam int FRAME_W = 16;
  localparam int CH_MSB  = 13;
  localparam int CH_LSB  = 11;
  localparam int PAD_W   = 4;

endpackage

// File: rtl/a2d_spi_slave_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, plus one-clk rise/fall
// pulses from comparing the synchronised value with its previous value.
module sync_edge_det
  import a2d_slv_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/a2d_spi_slave.sv
// SPI mode-0 responder modelling a pipelined 8-channel 12-bit A2D.
// Define A2D_SLV_INVERT_EN to return the inverted sample (inverting front end).
module a2d_spi_slave #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  input  logic [NUM_CH*DATA_W-1:0] smpl_data,
  output logic                     MISO,
  output logic [2:0]               chnnl_cur,
  output logic                     trans_done
);

  import a2d_slv_pkg::*;

  localparam int                PAD      = FRAME_W - DATA_W;
  localparam int                CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_sync_q;

  a2d_slv_state_t      state_q, state_d;
  logic [FRAME_W-1:0]  tx_shft_q, tx_shft_d;
  logic [FRAME_W-1:0]  rx_shft_q, rx_shft_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]          chnnl_q, chnnl_d;
  logic                done_q, done_d;

  sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS_n),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // MOSI needs only the two flops so it stays aligned with the SCLK rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Channels beyond NUM_CH read as zero before the optional inversion
  function automatic logic [DATA_W-1:0] pick_result(
    input logic [2:0]               ch,
    input logic [NUM_CH*DATA_W-1:0] data
  );
    logic [DATA_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch) == i) s = data[i*DATA_W +: DATA_W];
    end
`ifdef A2D_SLV_INVERT_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_shft_q <= '0;
      rx_shft_q <= '0;
      bit_cnt_q <= '0;
      chnnl_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_shft_q <= tx_shft_d;
      rx_shft_q <= rx_shft_d;
      bit_cnt_q <= bit_cnt_d;
      chnnl_q   <= chnnl_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_shft_d = tx_shft_q;
    rx_shft_d = rx_shft_q;
    bit_cnt_d = bit_cnt_q;
    chnnl_d   = chnnl_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          tx_shft_d = {{PAD{1'b0}}, pick_result(chnnl_q, smpl_data)};
          rx_shft_d = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CNT_FULL) begin
            chnnl_d = rx_shft_q[CH_MSB:CH_LSB];
            done_d  = 1'b1;
          end
        end else begin
          // Overlong frames keep shifting so the command is the last 16 bits
          if (sclk_rise) begin
            rx_shft_d = {rx_shft_q[FRAME_W-2:0], mosi_sync_q};
            if (bit_cnt_q != CNT_FULL) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (sclk_fall) tx_shft_d = {tx_shft_q[FRAME_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO       = tx_shft_q[FRAME_W-1];
  assign chnnl_cur  = chnnl_q;
  assign trans_done = done_q;

endmodule
